activation_arbiter: RTL

ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

---
 rtl/activation_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one activation unit among N requesters (ARG/RES[/ERR/FBK] per grant).
// Define ACTIV_ARB_FIXED_PRIORITY_EN to grant the lowest requesting index instead of round-robin.
module activation_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    train,
  input  logic [N-1:0]    req_arg_stb,
  output logic [N-1:0]    req_arg_rdy,
  input  logic [16*N-1:0] req_arg_dat,
  output logic [N-1:0]    req_res_stb,
  input  logic [N-1:0]    req_res_rdy,
  output logic [7:0]      req_res_dat,
  input  logic [N-1:0]    req_err_stb,
  input  logic [16*N-1:0] req_err_dat,
  output logic [N-1:0]    req_err_rdy,
  output logic [N-1:0]    req_fbk_stb,
  output logic [15:0]     req_fbk_dat,
  input  logic [N-1:0]    req_fbk_rdy,
  output logic            act_arg_stb,
  output logic [15:0]     act_arg_dat,
  input  logic            act_arg_rdy,
  input  logic            act_res_stb,
  input  logic [7:0]      act_res_dat,
  output logic            act_res_rdy,
  output logic            act_err_stb,
  output logic [15:0]     act_err_dat,
  input  logic            act_err_rdy,
  input  logic            act_fbk_stb,
  input  logic [15:0]     act_fbk_dat,
  output logic            act_fbk_rdy,
  output logic            act_en,
  output logic            act_rst,
  output logic            gnt_vld,
  output logic [IW-1:0]   gnt_id
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARG  = 3'd1,
    RES  = 3'd2,
    ERR  = 3'd3,
    FBK  = 3'd4
  } state_t;

  state_t          state_r, next_s;
  logic [IW-1:0]   gnt_id_r;
  logic [IW-1:0]   win_s;
  logic            act_en_r;
  logic            gnt_vld_r;
  logic [15:0]     arg_lane_s [N];
  logic [15:0]     err_lane_s [N];

`ifdef ACTIV_ARB_FIXED_PRIORITY_EN
  function automatic logic [IW-1:0] pick_winner(input logic [N-1:0] reqs);
    logic [IW-1:0] pick;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (reqs[k]) pick = k[IW-1:0];
    end
    return pick;
  endfunction

  assign win_s = pick_winner(req_arg_stb);
`else
  logic [IW-1:0] ptr_r;

  // Closest requester after the last grant wins, so scan far-to-near and let the nearest overwrite.
  function automatic logic [IW-1:0] pick_winner(input logic [N-1:0] reqs, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (reqs[idx]) pick = idx[IW-1:0];
    end
    return pick;
  endfunction

  assign win_s = pick_winner(req_arg_stb, ptr_r);
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign arg_lane_s[i] = req_arg_dat[16*i +: 16];
    assign err_lane_s[i] = req_err_dat[16*i +: 16];
  end

  assign act_rst     = ~rst;
  assign act_en      = act_en_r;
  assign gnt_vld     = gnt_vld_r;
  assign gnt_id      = gnt_id_r;
  assign req_res_dat = act_res_dat;
  assign req_fbk_dat = act_fbk_dat;

  // State register and grant capture; grant fields only change when leaving IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      gnt_vld_r <= 1'b0;
      gnt_id_r  <= '0;
      act_en_r  <= 1'b0;
`ifndef ACTIV_ARB_FIXED_PRIORITY_EN
      ptr_r     <= IW'(N - 1);
`endif
    end else begin
      state_r   <= next_s;
      gnt_vld_r <= (next_s != IDLE);
      if (state_r == IDLE && next_s == ARG) begin
        gnt_id_r <= win_s;
        act_en_r <= train[win_s];
`ifndef ACTIV_ARB_FIXED_PRIORITY_EN
        ptr_r    <= win_s;
`endif
      end
    end
  end

  // Next-state and handshake routing to/from the granted requester only.
  always_comb begin
    next_s      = state_r;
    req_arg_rdy = '0;
    req_res_stb = '0;
    req_err_rdy = '0;
    req_fbk_stb = '0;
    act_arg_stb = 1'b0;
    act_arg_dat = 16'h0000;
    act_res_rdy = 1'b0;
    act_err_stb = 1'b0;
    act_err_dat = 16'h0000;
    act_fbk_rdy = 1'b0;
    if (rst) begin
      case (state_r)
        IDLE: begin
          if (|req_arg_stb) next_s = ARG;
          else              next_s = IDLE;
        end
        ARG: begin
          act_arg_stb           = req_arg_stb[gnt_id_r];
          act_arg_dat           = arg_lane_s[gnt_id_r];
          req_arg_rdy[gnt_id_r] = act_arg_rdy;
          if (act_arg_stb && act_arg_rdy) next_s = RES;
          else                            next_s = ARG;
        end
        RES: begin
          req_res_stb[gnt_id_r] = act_res_stb;
          act_res_rdy           = req_res_rdy[gnt_id_r];
          if (act_res_stb && act_res_rdy) next_s = act_en_r ? ERR : IDLE;
          else                            next_s = RES;
        end
        ERR: begin
          act_err_stb           = req_err_stb[gnt_id_r];
          act_err_dat           = err_lane_s[gnt_id_r];
          req_err_rdy[gnt_id_r] = act_err_rdy;
          if (act_err_stb && act_err_rdy) next_s = FBK;
          else                            next_s = ERR;
        end
        FBK: begin
          req_fbk_stb[gnt_id_r] = act_fbk_stb;
          act_fbk_rdy           = req_fbk_rdy[gnt_id_r];
          if (act_fbk_stb && act_fbk_rdy) next_s = IDLE;
          else                            next_s = FBK;
        end
        default: next_s = IDLE;
      endcase
    end else begin
      next_s = IDLE;
    end
  end

endmodule
